// File: rtl/vga_linefetch.sv
// Line prefetcher: reads framebuffer words ahead of the beam into a 16-deep FIFO and serializes them as RGB332 pixels.
// Define VGA_LINEFETCH_UNDERRUN_EN to enable the sticky o_underrun flag.

module vga_linefetch (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_visible,
    input  logic        i_hSync,
    input  logic        i_vSync,
    input  logic        i_inth,
    input  logic        i_intv,
    input  logic [15:0] i_baseAddr,
    input  logic [7:0]  i_lineWords,
    output logic [15:0] o_memAddr,
    output logic        o_memReq,
    input  logic        i_memAck,
    input  logic [15:0] i_memData,
    output logic [7:0]  o_pixel,
    output logic        o_hSync,
    output logic        o_vSync,
    output logic        o_underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] fifo_mem [16];
    logic [3:0]  wr_idx;
    logic [3:0]  rd_idx;
    logic [4:0]  count;
    logic [15:0] addr_ptr;
    logic [15:0] drain_addr;
    logic [7:0]  word_cnt;
    logic        byte_sel;
    logic        line_visible;
    logic        frame_start;
    logic        line_end;
    logic        flush;
    logic        fetch_req;
    logic        fifo_wr;
    logic        fifo_empty;
    logic        pop;
    logic [15:0] head;

    // A flush discards everything, including a word acked in the same cycle.
    always_comb begin
        frame_start = i_inth && i_intv;
        line_end    = i_inth && !i_intv && (line_visible || i_visible);
        flush       = frame_start || line_end;
        fetch_req   = (state == FETCH) && (count < 5'd16) && (word_cnt < i_lineWords);
        fifo_wr     = fetch_req && i_memAck && !flush;
        fifo_empty  = (count == 5'd0);
        pop         = i_visible && !fifo_empty && byte_sel && !flush;
        head        = fifo_mem[rd_idx];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, FETCH: begin
                if (flush)
                    state_next = (fetch_req && !i_memAck) ? DRAIN : FETCH;
                else if ((state == FETCH) && (word_cnt == i_lineWords))
                    state_next = IDLE;
            end
            DRAIN: begin
                if (i_memAck) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // DRAIN holds the abandoned address so the bus sees a stable request until its ack.
    always_comb begin
        o_memReq  = fetch_req || (state == DRAIN);
        o_memAddr = (state == DRAIN) ? drain_addr : addr_ptr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_idx     <= 4'd0;
            rd_idx     <= 4'd0;
            count      <= 5'd0;
            addr_ptr   <= 16'd0;
            drain_addr <= 16'd0;
            word_cnt   <= 8'd0;
        end else if (flush) begin
            wr_idx   <= 4'd0;
            rd_idx   <= 4'd0;
            count    <= 5'd0;
            word_cnt <= 8'd0;
            if (frame_start)     addr_ptr   <= i_baseAddr;
            if (state != DRAIN)  drain_addr <= addr_ptr;
        end else begin
            if (fifo_wr) begin
                wr_idx   <= wr_idx + 4'd1;
                addr_ptr <= addr_ptr + 16'd1;
                word_cnt <= word_cnt + 8'd1;
            end
            if (pop) rd_idx <= rd_idx + 4'd1;
            count <= count + {4'd0, fifo_wr} - {4'd0, pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_wr) fifo_mem[wr_idx] <= i_memData;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_sel     <= 1'b0;
            line_visible <= 1'b0;
        end else if (i_inth) begin
            byte_sel     <= 1'b0;
            line_visible <= 1'b0;
        end else begin
            if (i_visible)                byte_sel     <= !byte_sel && !fifo_empty || byte_sel && fifo_empty;
            if (i_visible)                line_visible <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pixel <= 8'h00;
            o_hSync <= 1'b0;
            o_vSync <= 1'b0;
        end else begin
            o_pixel <= (i_visible && !fifo_empty) ? (byte_sel ? head[15:8] : head[7:0]) : 8'h00;
            o_hSync <= i_hSync;
            o_vSync <= i_vSync;
        end
    end

`ifdef VGA_LINEFETCH_UNDERRUN_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)                       o_underrun <= 1'b0;
        else if (i_visible && fifo_empty)  o_underrun <= 1'b1;
    end
`else
    assign o_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_vga_linefetch.sv
// Directed self-checking bench for vga_linefetch; address and pixel expectations flow through scoreboard queues.
// Honours VGA_LINEFETCH_UNDERRUN_EN for the expected underrun flag.

module tb_vga_linefetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_visible;
    logic        i_hSync;
    logic        i_vSync;
    logic        i_inth;
    logic        i_intv;
    logic [15:0] i_baseAddr;
    logic [7:0]  i_lineWords;
    logic [15:0] o_memAddr;
    logic        o_memReq;
    logic        i_memAck;
    logic [15:0] i_memData;
    logic [7:0]  o_pixel;
    logic        o_hSync;
    logic        o_vSync;
    logic        o_underrun;

    int tests_run = 0;
    int failures  = 0;
    logic [15:0] exp_addr [$];
    logic [7:0]  exp_pix [$];

`ifdef VGA_LINEFETCH_UNDERRUN_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    vga_linefetch dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_visible   (i_visible),
        .i_hSync     (i_hSync),
        .i_vSync     (i_vSync),
        .i_inth      (i_inth),
        .i_intv      (i_intv),
        .i_baseAddr  (i_baseAddr),
        .i_lineWords (i_lineWords),
        .o_memAddr   (o_memAddr),
        .o_memReq    (o_memReq),
        .i_memAck    (i_memAck),
        .i_memData   (i_memData),
        .o_pixel     (o_pixel),
        .o_hSync     (o_hSync),
        .o_vSync     (o_vSync),
        .o_underrun  (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Timing inputs are driven for one clock; the inth/intv pulse is dropped afterwards.
    task automatic apply_stimulus(input logic vis, input logic hs, input logic vs, input logic inth, input logic intv);
        i_visible = vis;
        i_hSync   = hs;
        i_vSync   = vs;
        i_inth    = inth;
        i_intv    = intv;
        @(negedge i_clk);
        i_inth = 1'b0;
        i_intv = 1'b0;
    endtask

    task automatic serve_req(input logic [15:0] data);
        logic [15:0] want;
        for (int n = 0; n < 20 && !o_memReq; n++) @(negedge i_clk);
        want = exp_addr.pop_front();
        check_output("req_wait", 16'(o_memReq), 16'd1);
        check_output("mem_addr", o_memAddr, want);
        i_memAck  = 1'b1;
        i_memData = data;
        @(negedge i_clk);
        i_memAck = 1'b0;
    endtask

    task automatic pixel_step(input logic [7:0] pix);
        exp_pix.push_back(pix);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("pixel", 16'(o_pixel), 16'(exp_pix.pop_front()));
    endtask

    initial begin
        i_reset = 1'b1; i_visible = 1'b0; i_hSync = 1'b0; i_vSync = 1'b0;
        i_inth = 1'b0; i_intv = 1'b0; i_memAck = 1'b0; i_memData = 16'h0000;
        i_baseAddr = 16'h1000; i_lineWords = 8'd4;
        repeat (3) @(negedge i_clk);
        check_output("rst_req", 16'(o_memReq), 16'd0);
        check_output("rst_addr", o_memAddr, 16'h0000);
        check_output("rst_pixel", 16'(o_pixel), 16'h0000);
        check_output("rst_hsync", 16'(o_hSync), 16'd0);
        check_output("rst_vsync", 16'(o_vSync), 16'd0);
        check_output("rst_underrun", 16'(o_underrun), 16'd0);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check_output("idle_before_frame", 16'(o_memReq), 16'd0);

        // Frame start, four words fetched back to back.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) exp_addr.push_back(16'h1000 + 16'(i));
        serve_req(16'h2211);
        serve_req(16'h4433);
        serve_req(16'h6655);
        serve_req(16'h8877);
        check_output("req_done", 16'(o_memReq), 16'd0);
        @(negedge i_clk);
        i_lineWords = 8'd8;
        @(negedge i_clk);
        check_output("idle_after_4", 16'(o_memReq), 16'd0);
        i_lineWords = 8'd4;

        // Pixel serialization with sync alignment.
        exp_pix.push_back(8'h11);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_output("pixel", 16'(o_pixel), 16'(exp_pix.pop_front()));
        check_output("hsync_hi", 16'(o_hSync), 16'd1);
        exp_pix.push_back(8'h22);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_output("pixel", 16'(o_pixel), 16'(exp_pix.pop_front()));
        check_output("hsync_lo", 16'(o_hSync), 16'd0);
        check_output("vsync_hi", 16'(o_vSync), 16'd1);
        pixel_step(8'h33);
        pixel_step(8'h44);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("pixel_blank", 16'(o_pixel), 16'h0000);
        check_output("no_underrun", 16'(o_underrun), 16'd0);

        // FIFO fills to 16 with ack held, then waits for space.
        i_lineWords = 8'd20;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        i_memAck = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_addr.push_back(16'h1004 + 16'(i));
            i_memData = 16'hA0B0 + 16'(i);
            check_output("fill_req", 16'(o_memReq), 16'd1);
            check_output("fill_addr", o_memAddr, exp_addr.pop_front());
            @(negedge i_clk);
        end
        check_output("full_req", 16'(o_memReq), 16'd0);
        repeat (2) @(negedge i_clk);
        i_memAck = 1'b0;
        check_output("full_req_held", 16'(o_memReq), 16'd0);
        check_output("full_addr", o_memAddr, 16'h1014);
        pixel_step(8'hB0);
        check_output("full_no_pop", 16'(o_memReq), 16'd0);
        pixel_step(8'hA0);
        check_output("space_req", 16'(o_memReq), 16'd1);
        check_output("space_addr", o_memAddr, 16'h1014);

        // Line end with request outstanding: ack three cycles later is discarded.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        i_lineWords = 8'd1;
        check_output("drain_req", 16'(o_memReq), 16'd1);
        check_output("drain_addr", o_memAddr, 16'h1014);
        @(negedge i_clk);
        check_output("drain_req2", 16'(o_memReq), 16'd1);
        check_output("drain_addr2", o_memAddr, 16'h1014);
        @(negedge i_clk);
        i_memAck  = 1'b1;
        i_memData = 16'hDEAD;
        @(negedge i_clk);
        i_memAck = 1'b0;
        exp_addr.push_back(16'h1014);
        serve_req(16'h5544);
        check_output("one_word_done", 16'(o_memReq), 16'd0);

        // One word then underrun.
        pixel_step(8'h44);
        pixel_step(8'h55);
        check_output("underrun_before", 16'(o_underrun), 16'd0);
        pixel_step(8'h00);
        check_output("underrun", 16'(o_underrun), 16'(UNDERRUN_EXP));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("underrun_sticky", 16'(o_underrun), 16'(UNDERRUN_EXP));

        // Pointer wrap.
        i_baseAddr  = 16'hFFFF;
        i_lineWords = 8'd2;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_addr.push_back(16'hFFFF);
        exp_addr.push_back(16'h0000);
        serve_req(16'h0102);
        serve_req(16'h0304);
        check_output("wrap_done", 16'(o_memReq), 16'd0);
        check_output("wrap_ptr", o_memAddr, 16'h0001);

        // Zero-length line goes straight to idle.
        i_lineWords = 8'd0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output("zero_req", 16'(o_memReq), 16'd0);
        @(negedge i_clk);
        i_lineWords = 8'd4;
        @(negedge i_clk);
        check_output("zero_idle", 16'(o_memReq), 16'd0);

        // Reset abandons an outstanding request; a late ack is ignored.
        i_baseAddr = 16'h3000;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_output("pre_rst_req", 16'(o_memReq), 16'd1);
        check_output("pre_rst_addr", o_memAddr, 16'h3000);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        check_output("abandon_req", 16'(o_memReq), 16'd0);
        check_output("abandon_addr", o_memAddr, 16'h0000);
        check_output("abandon_underrun", 16'(o_underrun), 16'd0);
        i_memAck = 1'b1;
        @(negedge i_clk);
        i_memAck = 1'b0;
        @(negedge i_clk);
        check_output("late_ack_req", 16'(o_memReq), 16'd0);
        check_output("late_ack_addr", o_memAddr, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
